// File: rtl/maze_memory.sv
// -----------------------------------------------------------------------------
// maze_memory
//
// Responder side of the maze solver's access interface. It holds the wall
// bitmap and the visited bitmap, answers solver reads one cycle after the
// request, counts distinct marked cells, and captures the exit cell when the
// solver reports completion.
//
// Operating states:
//   LOAD     : the loader writes wall cells; `start` moves to RUN.
//   RUN      : the solver reads walls and marks cells; `done` moves to FINISHED.
//   FINISHED : results are frozen; `clear` returns to LOAD with walls kept.
//
// Optional feature macro: MAZE_STEP_CNT_EN
//   When defined, adds the 16-bit `step_count` output, which counts the
//   accepted solver reads in RUN and saturates at 16'hFFFF.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   load_we/row/col/wall     loader write of one wall cell (LOAD only)
//   start, clear             LOAD->RUN and FINISHED->LOAD pulses
//   row, col                 solver access coordinates
//   maze_oe, maze_we         solver read and mark requests
//   done                     solver exit-found indication
//   maze_in                  registered wall bit of the last read cell
//   running, exit_valid      high in RUN / FINISHED respectively
//   exit_row, exit_col       captured exit cell
//   mark_count               distinct cells marked in this run (saturating)
//   protocol_err             sticky protocol violation flag
//   step_count               accepted reads in RUN (MAZE_STEP_CNT_EN only)
// -----------------------------------------------------------------------------
module maze_memory #(
   parameter int maze_width = 6,
   parameter int CNT_W      = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_we,
   input  logic [maze_width-1:0] load_row,
   input  logic [maze_width-1:0] load_col,
   input  logic                  load_wall,
   input  logic                  start,
   input  logic                  clear,
   input  logic [maze_width-1:0] row,
   input  logic [maze_width-1:0] col,
   input  logic                  maze_oe,
   input  logic                  maze_we,
   input  logic                  done,
   output logic                  maze_in,
   output logic                  running,
   output logic                  exit_valid,
   output logic [maze_width-1:0] exit_row,
   output logic [maze_width-1:0] exit_col,
   output logic [CNT_W-1:0]      mark_count,
   output logic                  protocol_err
`ifdef MAZE_STEP_CNT_EN
   ,
   output logic [15:0]           step_count
`endif
);

   localparam int IDX_W = 2 * maze_width;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {
      S_LOAD     = 2'd0,
      S_RUN      = 2'd1,
      S_FINISHED = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic                  wall_mem [DEPTH];
   logic [DEPTH-1:0]      visited_q;
   logic                  maze_in_q;
   logic [maze_width-1:0] exit_row_q;
   logic [maze_width-1:0] exit_col_q;
   logic [CNT_W-1:0]      mark_count_q;
   logic                  protocol_err_q;

   logic [IDX_W-1:0] load_idx;
   logic [IDX_W-1:0] acc_idx;
   logic             in_load, in_run;
   logic             rd_en, mk_en, new_mark, err_set;

   assign load_idx = {load_row, load_col};
   assign acc_idx  = {row, col};
   assign in_load  = (state_q == S_LOAD);
   assign in_run   = (state_q == S_RUN);
   assign rd_en    = in_run && maze_oe;
   assign mk_en    = in_run && maze_we;
   assign new_mark = mk_en && !visited_q[acc_idx];

   // Violations: solver traffic during LOAD, loader traffic during RUN, or a
   // simultaneous read and mark. FINISHED tolerates solver traffic silently.
   assign err_set  = (in_load && (maze_oe || maze_we)) ||
                     (in_run && (load_we || (maze_oe && maze_we)));

   // ---------------------------------------------------------------- FSM
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD:     if (start) state_d = S_RUN;
         S_RUN:      if (done)  state_d = S_FINISHED;
         S_FINISHED: if (clear) state_d = S_LOAD;
         default:               state_d = S_LOAD;
      endcase
   end

   // ---------------------------------------------------------------- storage
   // NOTE: the wall array has no reset on purpose so it can map onto RAM; it
   // is always reloaded before use. The visited bitmap must be reset because
   // mark_count depends on it starting clear.
   always_ff @(posedge clk) begin
      if (in_load && load_we) wall_mem[load_idx] <= load_wall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         visited_q <= '0;
      end else if (in_load && start) begin
         visited_q <= '0;
      end else if (mk_en) begin
         visited_q[acc_idx] <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maze_in_q      <= 1'b0;
         exit_row_q     <= '0;
         exit_col_q     <= '0;
         mark_count_q   <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         // Synchronous read; holds its value whenever no read is accepted.
         if (rd_en) maze_in_q <= wall_mem[acc_idx];

         if (in_run && done) begin
            exit_row_q <= row;
            exit_col_q <= col;
         end

         if (in_load && start)
            mark_count_q <= '0;
         else if (new_mark && (mark_count_q != '1))
            mark_count_q <= mark_count_q + CNT_W'(1);

         if (err_set) protocol_err_q <= 1'b1;
      end
   end

`ifdef MAZE_STEP_CNT_EN
   logic [15:0] step_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         step_count_q <= '0;
      else if (in_load && start)
         step_count_q <= '0;
      else if (rd_en && (step_count_q != 16'hFFFF))
         step_count_q <= step_count_q + 16'd1;
   end

   assign step_count = step_count_q;
`endif

   assign maze_in      = maze_in_q;
   assign running      = in_run;
   assign exit_valid   = (state_q == S_FINISHED);
   assign exit_row     = exit_row_q;
   assign exit_col     = exit_col_q;
   assign mark_count   = mark_count_q;
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_maze_memory.sv
// -----------------------------------------------------------------------------
// tb_maze_memory
//
// Directed bench for maze_memory: wall load and 1-cycle read latency, read
// hold, distinct-mark counting, exit capture and freeze, clear/rerun with
// walls kept, protocol error flag, and asynchronous reset mid-run.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_maze_memory;

   localparam int MW = 6;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_we, load_wall, start, clear;
   logic [MW-1:0] load_row, load_col, row, col;
   logic          maze_oe, maze_we, done;
   logic          maze_in, running, exit_valid, protocol_err;
   logic [MW-1:0] exit_row, exit_col;
   logic [CW-1:0] mark_count;
`ifdef MAZE_STEP_CNT_EN
   logic [15:0]   step_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   maze_memory #(.maze_width(MW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_we      (load_we),
      .load_row     (load_row),
      .load_col     (load_col),
      .load_wall    (load_wall),
      .start        (start),
      .clear        (clear),
      .row          (row),
      .col          (col),
      .maze_oe      (maze_oe),
      .maze_we      (maze_we),
      .done         (done),
      .maze_in      (maze_in),
      .running      (running),
      .exit_valid   (exit_valid),
      .exit_row     (exit_row),
      .exit_col     (exit_col),
      .mark_count   (mark_count),
      .protocol_err (protocol_err)
`ifdef MAZE_STEP_CNT_EN
      ,
      .step_count   (step_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_cell(input logic [MW-1:0] r, input logic [MW-1:0] c, input logic w);
      load_we = 1'b1; load_row = r; load_col = c; load_wall = w;
   endtask

   task automatic access(input logic oe, input logic we, input logic [MW-1:0] r, input logic [MW-1:0] c);
      maze_oe = oe; maze_we = we; row = r; col = c;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".maze_in"},      32'(maze_in),      32'd0);
      check({tag, ".running"},      32'(running),      32'd0);
      check({tag, ".exit_valid"},   32'(exit_valid),   32'd0);
      check({tag, ".exit_row"},     32'(exit_row),     32'd0);
      check({tag, ".exit_col"},     32'(exit_col),     32'd0);
      check({tag, ".mark_count"},   32'(mark_count),   32'd0);
      check({tag, ".protocol_err"}, 32'(protocol_err), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      load_we = 1'b0; load_row = '0; load_col = '0; load_wall = 1'b0;
      start = 1'b0; clear = 1'b0; done = 1'b0;
      access(1'b0, 1'b0, '0, '0);

      // ---- reset state
      tick(); tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      // ---- load walls; start coincides with a final load that must still land
      load_cell(6'd5, 6'd7, 1'b1); tick();
      load_cell(6'd5, 6'd8, 1'b0); tick();
      load_cell(6'd20, 6'd20, 1'b1); start = 1'b1; tick();
      load_we = 1'b0; start = 1'b0;
      check("start.running", 32'(running), 32'd1);
      check("start.mark_count", 32'(mark_count), 32'd0);

      // ---- back-to-back reads, one cycle latency
      access(1'b1, 1'b0, 6'd5, 6'd7); tick();
      check("rd57", 32'(maze_in), 32'd1);
      access(1'b1, 1'b0, 6'd5, 6'd8); tick();
      check("rd58", 32'(maze_in), 32'd0);
      access(1'b1, 1'b0, 6'd20, 6'd20); tick();
      check("rd_20_20_with_start", 32'(maze_in), 32'd1);
      // maze_in holds while oe is low even though (5,8) is a corridor
      access(1'b0, 1'b0, 6'd5, 6'd8); tick(); tick();
      check("rd_hold", 32'(maze_in), 32'd1);

      // ---- marking: (10,10) three times, (10,11) once
      access(1'b0, 1'b1, 6'd10, 6'd10); tick();
      check("mark1", 32'(mark_count), 32'd1);
      tick(); tick();
      check("mark_repeat", 32'(mark_count), 32'd1);
      access(1'b0, 1'b1, 6'd10, 6'd11); tick();
      check("mark2", 32'(mark_count), 32'd2);
      check("mark.protocol_err", 32'(protocol_err), 32'd0);

      // ---- exit capture with a same-cycle mark
      done = 1'b1;
      access(1'b0, 1'b1, 6'd0, 6'd33); tick();
      check("exit.valid", 32'(exit_valid), 32'd1);
      check("exit.running", 32'(running), 32'd0);
      check("exit.row", 32'(exit_row), 32'd0);
      check("exit.col", 32'(exit_col), 32'd33);
      check("exit.mark_count", 32'(mark_count), 32'd3);
`ifdef MAZE_STEP_CNT_EN
      check("exit.step_count", 32'(step_count), 32'd3);
`endif

      // ---- FINISHED: done held, accesses ignored and harmless
      access(1'b1, 1'b1, 6'd5, 6'd8); tick(); tick();
      check("fin.maze_in", 32'(maze_in), 32'd1);
      check("fin.mark_count", 32'(mark_count), 32'd3);
      check("fin.exit_row", 32'(exit_row), 32'd0);
      check("fin.exit_col", 32'(exit_col), 32'd33);
      check("fin.exit_valid", 32'(exit_valid), 32'd1);
      check("fin.protocol_err", 32'(protocol_err), 32'd0);
`ifdef MAZE_STEP_CNT_EN
      check("fin.step_count", 32'(step_count), 32'd3);
`endif

      // ---- clear, then rerun without reloading
      done = 1'b0;
      access(1'b0, 1'b0, '0, '0);
      clear = 1'b1; tick(); clear = 1'b0;
      check("clear.exit_valid", 32'(exit_valid), 32'd0);
      check("clear.running", 32'(running), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      check("rerun.running", 32'(running), 32'd1);
      check("rerun.mark_count", 32'(mark_count), 32'd0);
      access(1'b1, 1'b0, 6'd5, 6'd7); tick();
      check("rerun.rd57", 32'(maze_in), 32'd1);
      // visited bitmap was cleared by start, so (10,10) counts again
      access(1'b0, 1'b1, 6'd10, 6'd10); tick();
      check("rerun.mark", 32'(mark_count), 32'd1);

      // ---- read and mark together: both happen, error flagged
      access(1'b1, 1'b1, 6'd5, 6'd8); tick();
      check("both.maze_in", 32'(maze_in), 32'd0);
      check("both.mark_count", 32'(mark_count), 32'd2);
      check("both.protocol_err", 32'(protocol_err), 32'd1);

      // ---- load_we in RUN is ignored
      access(1'b0, 1'b0, '0, '0);
      load_cell(6'd5, 6'd8, 1'b1); tick(); load_we = 1'b0;
      access(1'b1, 1'b0, 6'd5, 6'd8); tick();
      check("run_load_ignored", 32'(maze_in), 32'd0);
      access(1'b1, 1'b0, 6'd5, 6'd7); tick();
      check("run_rd57_again", 32'(maze_in), 32'd1);

      // ---- async reset between edges while running
      access(1'b0, 1'b0, '0, '0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
`ifdef MAZE_STEP_CNT_EN
      check("async_rst.step_count", 32'(step_count), 32'd0);
`endif
      tick(); rst_n = 1'b1;

      // ---- solver read in LOAD flags an error (also proves reset went to LOAD)
      access(1'b1, 1'b0, 6'd1, 6'd1); tick();
      access(1'b0, 1'b0, '0, '0);
      check("load_oe.protocol_err", 32'(protocol_err), 32'd1);
      check("load_oe.maze_in", 32'(maze_in), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      check("sticky_start", 32'(protocol_err), 32'd1);
      for (int i = 0; i < 4; i++) begin
         access(1'b1, 1'b0, 6'(i), 6'd2); tick();
      end
      access(1'b0, 1'b0, '0, '0);
`ifdef MAZE_STEP_CNT_EN
      check("four_reads.step_count", 32'(step_count), 32'd4);
`endif
      done = 1'b1; tick(); done = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;
      check("sticky_clear", 32'(protocol_err), 32'd1);
      check("sticky_clear.exit_valid", 32'(exit_valid), 32'd0);

      // ---- only reset clears the error flag
      #2 rst_n = 1'b0;
      #1 check("rst_clears_err", 32'(protocol_err), 32'd0);
`ifdef MAZE_STEP_CNT_EN
      check("rst.step_count", 32'(step_count), 32'd0);
`endif
      tick(); rst_n = 1'b1; tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/maze_memory.md
Name: maze_memory

Overview:
- Responder side of the solver's maze access interface: stores the 2^maze_width x 2^maze_width wall bitmap and answers each `maze_oe` read with `maze_in` on the next cycle.
- Records every `maze_we` mark in a separate visited bitmap.
- Captures the exit cell when the solver raises `done`.
- Sits between the testbench/loader and the solver; the bitmap is loaded cell by cell before each run.

Parameters:
- `maze_width`, 6, bits per coordinate; the maze is 2^maze_width cells per side (64x64 by default).
- `CNT_W`, 13, width of `mark_count`; must hold 2^(2*maze_width) (4096 needs 13 bits).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load_we` in 1: write one wall cell (LOAD state only).
- `load_row` in `maze_width`: row of the cell being loaded.
- `load_col` in `maze_width`: column of the cell being loaded.
- `load_wall` in 1: 1 = wall, 0 = corridor.
- `start` in 1: one-cycle pulse, LOAD -> RUN.
- `clear` in 1: one-cycle pulse, FINISHED -> LOAD.
- `row` in `maze_width`: solver access row.
- `col` in `maze_width`: solver access column.
- `maze_oe` in 1: solver read request.
- `maze_we` in 1: solver mark request.
- `done` in 1: solver exit-found indication.
- `maze_in` out 1: registered wall bit of the last read cell.
- `running` out 1: high in RUN.
- `exit_valid` out 1: high in FINISHED.
- `exit_row` out `maze_width`: captured exit row.
- `exit_col` out `maze_width`: captured exit column.
- `mark_count` out `CNT_W`: number of distinct cells marked this run.
- `protocol_err` out 1: sticky protocol violation flag.

Behaviour:
- Reset (async, `rst_n` = 0), all outputs and state:
  - state = LOAD.
  - `maze_in` = 0, `running` = 0, `exit_valid` = 0.
  - `exit_row` = 0, `exit_col` = 0, `mark_count` = 0, `protocol_err` = 0.
  - Visited bitmap fully cleared.
  - Wall bitmap contents undefined; it must be reloaded.
- Reset mid-run aborts immediately; no completion is reported.
- States: LOAD, RUN, FINISHED.
- LOAD:
  - `load_we` = 1 writes `wall[load_row][load_col]` <= `load_wall` at the clock edge.
  - Solver `maze_oe`/`maze_we` are ignored and set `protocol_err`.
  - `start` = 1 -> RUN next cycle. The same edge clears the visited bitmap and zeroes `mark_count`.
  - If `start` and `load_we` are high in the same cycle, the load is still performed.
- RUN (`running` = 1):
  - Read: `maze_oe` = 1 at edge N -> `maze_in` = `wall[row][col]` after edge N, valid for the whole cycle N+1. Latency is exactly 1 cycle.
  - `maze_in` holds its value while `maze_oe` = 0.
  - Mark: `maze_we` = 1 at an edge sets `visited[row][col]`. `mark_count` increments only if that cell was previously unvisited.
  - Re-marking a visited cell leaves the count unchanged.
  - `mark_count` saturates at all-ones.
  - `maze_oe` and `maze_we` both high in one cycle: both operations are performed and `protocol_err` is set.
  - `load_we` in RUN is ignored and sets `protocol_err`.
  - `done` = 1 at an edge:
    - captures `exit_row`/`exit_col` from the current `row`/`col`;
    - -> FINISHED next cycle;
    - a `maze_we` in the same cycle is still applied.
  - `start` and `clear` are ignored in RUN.
- FINISHED (`exit_valid` = 1):
  - Exit registers, `mark_count` and `maze_in` are frozen.
  - The solver holds `done` high; this is legal.
  - `maze_oe`/`maze_we` are ignored and do not set `protocol_err`.
  - `clear` = 1 -> LOAD next cycle. The wall bitmap is kept, so a rerun needs only `start`.
  - `exit_valid` drops on entry to LOAD.
- Coordinates are unsigned and cover the full array; there are no out-of-range cells.
- `protocol_err` is cleared only by reset.
- Storage: two 2^(2*maze_width)-bit arrays indexed `{row, col}`. Register-based or inferred RAM with a synchronous read; both are acceptable.

Optional Feature:
- Macro: `MAZE_STEP_CNT_EN`.
- Defined:
  - Adds output `step_count` (16 bits): the count of `maze_oe` cycles accepted in RUN.
  - Saturates at 16'hFFFF.
  - Zeroed on `start` and on reset; frozen in FINISHED.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load/read/latency: load `wall[5][7]` = 1 and `wall[5][8]` = 0, `start`; `maze_oe` with (5,7), then (5,8) on back-to-back cycles -> `maze_in` = 1 then 0, each one cycle after its request; `maze_in` holds 0 while `maze_oe` stays low.
- Marking: `maze_we` on (10,10) three times and on (10,11) once -> `mark_count` = 2; `protocol_err` = 0.
- Exit capture: drive `done` = 1 with `row` = 0, `col` = 33 and `maze_we` = 1 -> next cycle `exit_valid` = 1, exit = (0,33), `mark_count` incremented by 1; later accesses change nothing.
- Clear/rerun: `clear`, then `start` without reloading -> `wall[5][7]` still reads 1; `mark_count` = 0; `exit_valid` = 0 from the cycle after `clear`.
- Protocol errors:
  - `maze_oe` in LOAD -> `protocol_err` = 1, sticky through `start`/`clear`, cleared only by `rst_n`.
  - `maze_oe` and `maze_we` together in RUN -> `protocol_err` = 1, and the read and the mark both still occur.
- Async reset: assert `rst_n` = 0 mid-RUN between clock edges -> all outputs zero immediately, state LOAD; with `MAZE_STEP_CNT_EN` defined, after 4 reads the count is 4, and it is 0 after reset.
